// File: rtl/isp_frame_capture.sv
// isp_frame_capture: receiving end of the ISP pixel stream.
// Rebuilds x/y from the line/frame strobes, captures one WIDTH x HEIGHT frame
// into an internal buffer, then freezes it for random-access readout until
// the consumer releases it.
// Optional macro ISP_CAPTURE_STATS_EN adds sum/max/min statistics outputs.
`timescale 1ns/1ps
module isp_frame_capture #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid,
   input  logic              line_sync,
   input  logic              frame_sync,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              rd_release,
   output logic              frame_ready,
   output logic              capturing,
   output logic              err_geom,
   output logic [15:0]       drop_cnt
`ifdef ISP_CAPTURE_STATS_EN
   ,
   output logic [DATA_W+ADDR_W-1:0] stat_sum,
   output logic [DATA_W-1:0]        stat_max,
   output logic [DATA_W-1:0]        stat_min
`endif
);

   localparam int DEPTH = WIDTH * HEIGHT;
   localparam int XW    = $clog2(WIDTH + 1);
   localparam int YW    = $clog2(HEIGHT + 1);
   localparam int BW    = ADDR_W + 1;

   localparam logic [XW-1:0] X_END     = XW'(WIDTH);
   localparam logic [YW-1:0] Y_END     = YW'(HEIGHT);
   localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
   localparam logic [BW-1:0] BASE_STEP = BW'(WIDTH);
   localparam logic [BW-1:0] DEPTH_L   = BW'(DEPTH);

   typedef enum logic [1:0] {SYNC_WAIT, CAPTURE, READY} state_t;

   state_t            state_q;
   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   // running line base y*WIDTH; one extra bit so it can reach WIDTH*HEIGHT
   logic [BW-1:0]     base_q;
   logic              frame_ready_q;
   logic              capturing_q;
   logic              err_geom_q;
   logic [15:0]       drop_cnt_q;
   logic [15:0]       drop_cnt_d;
   logic [DATA_W-1:0] rd_data_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_cap;
   logic              in_range;
   logic              wr_en;
   logic              geom_px;
   logic              start_cap;
   logic [XW-1:0]     x_post;
   logic [ADDR_W-1:0] wr_addr;

   // Per-cycle decode: pixel write first, strobes then see the updated x
   always_comb begin
      in_cap     = (state_q == CAPTURE);
      in_range   = (x_q < X_END) && (y_q < Y_END);
      wr_en      = in_cap && pix_valid && in_range;
      geom_px    = in_cap && pix_valid && !in_range;
      x_post     = wr_en ? x_q + 1'b1 : x_q;
      wr_addr    = ADDR_W'(base_q + BW'(x_q));
      start_cap  = frame_sync && ((state_q == SYNC_WAIT) ||
                                  (state_q == READY && rd_release));
      drop_cnt_d = drop_cnt_q;
      if (pix_valid && !in_cap && drop_cnt_q != 16'hFFFF)
         drop_cnt_d = drop_cnt_q + 16'd1;
   end

   // Capture FSM with coordinate tracking and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= SYNC_WAIT;
         x_q           <= '0;
         y_q           <= '0;
         base_q        <= '0;
         frame_ready_q <= 1'b0;
         capturing_q   <= 1'b0;
         err_geom_q    <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         if (start_cap) begin
            state_q       <= CAPTURE;
            x_q           <= '0;
            y_q           <= '0;
            base_q        <= '0;
            err_geom_q    <= 1'b0;
            capturing_q   <= 1'b1;
            frame_ready_q <= 1'b0;
         end else begin
            case (state_q)
               CAPTURE: begin
                  x_q <= x_post;
                  if (geom_px) err_geom_q <= 1'b1;
                  if (frame_sync) begin
                     // last line is closed by frame_sync itself
                     if (!(x_post == X_END && y_q == Y_LAST)) err_geom_q <= 1'b1;
                     state_q       <= READY;
                     frame_ready_q <= 1'b1;
                     capturing_q   <= 1'b0;
                  end else if (line_sync) begin
                     if (x_post != X_END) err_geom_q <= 1'b1;
                     x_q <= '0;
                     if (y_q != Y_END) begin
                        y_q    <= y_q + 1'b1;
                        base_q <= base_q + BASE_STEP;
                     end
                  end
               end
               READY: begin
                  if (rd_release) begin
                     state_q       <= SYNC_WAIT;
                     frame_ready_q <= 1'b0;
                  end
               end
               default: state_q <= SYNC_WAIT;
            endcase
         end
      end
   end

   // Frame buffer write port (no reset: contents undefined after reset)
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= pix_in;
   end

   // Registered readout; a same-cycle write is not visible until next read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if ({1'b0, rd_addr} < DEPTH_L) begin
         rd_data_q <= mem[rd_addr];
      end else begin
         rd_data_q <= '0;
      end
   end

   assign rd_data     = rd_data_q;
   assign frame_ready = frame_ready_q;
   assign capturing   = capturing_q;
   assign err_geom    = err_geom_q;
   assign drop_cnt    = drop_cnt_q;

`ifdef ISP_CAPTURE_STATS_EN
   logic [DATA_W+ADDR_W-1:0] stat_sum_q;
   logic [DATA_W-1:0]        stat_max_q;
   logic [DATA_W-1:0]        stat_min_q;

   // Statistics over written pixels, restarted on each capture entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_sum_q <= '0;
         stat_max_q <= '0;
         stat_min_q <= '1;
      end else if (start_cap) begin
         stat_sum_q <= '0;
         stat_max_q <= '0;
         stat_min_q <= '1;
      end else if (wr_en) begin
         stat_sum_q <= stat_sum_q + {{ADDR_W{1'b0}}, pix_in};
         if (pix_in > stat_max_q) stat_max_q <= pix_in;
         if (pix_in < stat_min_q) stat_min_q <= pix_in;
      end
   end

   assign stat_sum = stat_sum_q;
   assign stat_max = stat_max_q;
   assign stat_min = stat_min_q;
`endif

endmodule
